code_word_loader: RTL and testbench
===================================

CODE_WORD_LOADER -- requirements
Module: code_word_loader

Interface
REQ-001 SHALL have parameter ANTS, default 32: antennas per codeword row.
REQ-002 SHALL have parameter WIDTH, default 32: bits per antenna coefficient.
REQ-003 SHALL have parameter DEPTH, default 64: codeword indices per table.
REQ-004 SHALL have parameter SEGS, default 4: stream beats per row; BW = WIDTH*ANTS/SEGS, default 256.
REQ-005 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port i_start, input, 1: one-cycle pulse that arms a table load.
REQ-008 SHALL have port s_axis_tdata, input, BW: codeword segment; segment 0 carries bits [BW-1:0] of the row.
REQ-009 SHALL have port s_axis_tvalid, input, 1: segment valid.
REQ-010 SHALL have port s_axis_tlast, input, 1: marks the final beat of the table.
REQ-011 SHALL have port s_axis_tready, output, 1: loader accepts the beat.
REQ-012 SHALL have port o_wr_en, output, 1: codeword RAM write strobe.
REQ-013 SHALL have port o_wr_sel, output, 1: target table; 0 = even, 1 = odd.
REQ-014 SHALL have port o_wr_addr, output, clog2(DEPTH): codeword index.
REQ-015 SHALL have port o_wr_data, output, WIDTH*ANTS: assembled row.
REQ-016 SHALL have port o_done, output, 1: level; table loaded cleanly.
REQ-017 SHALL have port o_err, output, 1: level; framing error.

Function
REQ-018 SHALL accept a beat only on cycles where s_axis_tvalid and s_axis_tready are both 1.
REQ-019 SHALL implement an FSM with states IDLE, LOAD, DONE, ERR; s_axis_tready SHALL be 1 only in LOAD.
REQ-020 SHALL go IDLE->LOAD on i_start; i_start in DONE or ERR SHALL clear o_done/o_err, zero the counters and enter LOAD; i_start in LOAD SHALL be ignored.
REQ-021 SHALL order rows as index k even, then index k odd, for k = 0..DEPTH-1: 2*DEPTH rows, 2*DEPTH*SEGS beats per table.
REQ-022 SHALL keep a segment counter (0..SEGS-1), a parity bit and an index counter; each wraps or advances only on an accepted beat.
REQ-023 SHALL assert o_wr_en for exactly one cycle, the cycle after segment SEGS-1 of a row is accepted, with o_wr_sel = parity and o_wr_addr = index of that row.
REQ-024 SHALL hold o_wr_data, o_wr_sel and o_wr_addr stable until the next write.
REQ-025 SHALL go LOAD->DONE on the accepted final beat (index DEPTH-1, odd, segment SEGS-1) when tlast=1; o_done rises the same cycle as the last o_wr_en.
REQ-026 SHALL go LOAD->ERR when an accepted beat has tlast=1 before the final beat; that partial row SHALL NOT be written.
REQ-027 SHALL go LOAD->ERR when the final beat is accepted with tlast=0, and that row SHALL still be written.
REQ-028 SHALL leave o_done and o_err mutually exclusive; both hold until i_start or reset.
REQ-029 SHALL NOT create idle bubbles: back-to-back valid beats SHALL be accepted every cycle in LOAD.

Reset
REQ-030 SHALL, while i_reset_n=0 at a clock edge, put the FSM in IDLE and drive s_axis_tready=0, o_wr_en=0, o_wr_sel=0, o_wr_addr=0, o_wr_data=0, o_done=0, o_err=0, with all counters zero.
REQ-031 SHALL abort an in-progress load on reset with no further o_wr_en; a new i_start is required afterwards.

Structure
REQ-032 SHALL take the defaults for ANTS, WIDTH, DEPTH and SEGS, and the FSM state enum, from shared package cw_pkg, which is also used by the codeword reader.
REQ-033 SHALL use one natural sub-module, cw_row_assembler, containing the segment shift register and segment counter.

Verification
REQ-034 SHALL cover a clean load: start, then 512 back-to-back beats with tlast on beat 511 -> 128 writes; index 5 odd lands at addr 5, sel=1; o_done=1, o_err=0.
REQ-035 SHALL cover throttling: random tvalid gaps during a clean load -> identical write sequence and data; no write while tvalid stalls mid-row.
REQ-036 SHALL cover early tlast: tlast on beat 9 -> writes for rows 0 and 1 only (addr 0 sel 0, addr 0 sel 1), then ERR, tready=0.
REQ-037 SHALL cover missing tlast: 512 beats with tlast=0 -> 128 writes, then o_err=1, o_done=0.
REQ-038 SHALL cover reset mid-load: i_reset_n low after beat 100 -> all outputs 0, no further writes; a restart then loads cleanly.
REQ-039 SHALL cover restart: i_start while in DONE -> o_done clears next cycle and the reload begins at addr 0, sel 0.

Source files
------------

// File: rtl/cw_pkg.sv
// Shared codeword-table definitions for the loader and the codeword reader.
package cw_pkg;

  localparam int unsigned CwAnts  = 32;
  localparam int unsigned CwWidth = 32;
  localparam int unsigned CwDepth = 64;
  localparam int unsigned CwSegs  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone,
    StErr
  } cw_state_e;

endpackage

// File: rtl/code_word_loader_if.sv
// AXI-Stream style segment input to the codeword loader.
interface code_word_loader_if
  import cw_pkg::*;
#(
  parameter int unsigned BW = CwWidth * CwAnts / CwSegs
) ();

  logic [BW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready
  );

endinterface

// File: rtl/cw_row_assembler.sv
// Collects SEGS stream beats into one codeword row; segment 0 ends up in the low bits.
module cw_row_assembler
  import cw_pkg::*;
#(
  parameter int unsigned BW   = CwWidth * CwAnts / CwSegs,
  parameter int unsigned SEGS = CwSegs
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               beat_i,
  input  logic [BW-1:0]      data_i,
  output logic               seg_last_o,
  output logic [BW*SEGS-1:0] row_o
);

  localparam int unsigned SegW = (SEGS > 1) ? $clog2(SEGS) : 1;
  localparam int unsigned ShW  = BW * (SEGS - 1);

  logic [SegW-1:0] seg_q, seg_d;
  logic [ShW-1:0]  sr_q, sr_d;

  assign seg_last_o = (seg_q == SegW'(SEGS - 1));
  // Row as it stands once the current beat is included.
  assign row_o      = {data_i, sr_q};

  always_comb begin
    seg_d = seg_q;
    sr_d  = sr_q;
    if (clear_i) begin
      seg_d = '0;
    end else if (beat_i) begin
      sr_d  = row_o[BW*SEGS-1:BW];
      seg_d = seg_last_o ? '0 : seg_q + SegW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      seg_q <= '0;
      sr_q  <= '0;
    end else begin
      seg_q <= seg_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/code_word_loader.sv
// Loads an even/odd codeword table pair from a segmented stream into codeword RAM.
module code_word_loader
  import cw_pkg::*;
#(
  parameter  int unsigned ANTS  = CwAnts,
  parameter  int unsigned WIDTH = CwWidth,
  parameter  int unsigned DEPTH = CwDepth,
  parameter  int unsigned SEGS  = CwSegs,
  localparam int unsigned BW    = WIDTH * ANTS / SEGS,
  localparam int unsigned RowW  = WIDTH * ANTS,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_start,
  code_word_loader_if.slave   s_axis,
  output logic                o_wr_en,
  output logic                o_wr_sel,
  output logic [AW-1:0]       o_wr_addr,
  output logic [RowW-1:0]     o_wr_data,
  output logic                o_done,
  output logic                o_err
);

  cw_state_e       state_q, state_d;
  logic            parity_q, parity_d;
  logic [AW-1:0]   index_q, index_d;
  logic            accept, restart, seg_last, final_beat, early_last, row_write;
  logic [RowW-1:0] row;

  assign s_axis.s_axis_tready = (state_q == StLoad);
  assign accept     = s_axis.s_axis_tvalid && s_axis.s_axis_tready;
  assign restart    = i_start && (state_q != StLoad);
  assign final_beat = seg_last && parity_q && (index_q == AW'(DEPTH - 1));
  // A tlast before the table end aborts: the row in flight is dropped.
  assign early_last = accept && s_axis.s_axis_tlast && !final_beat;
  assign row_write  = accept && seg_last && !early_last;

  cw_row_assembler #(
    .BW   (BW),
    .SEGS (SEGS)
  ) u_row_assembler (
    .clk_i      (i_clk),
    .rst_ni     (i_reset_n),
    .clear_i    (restart),
    .beat_i     (accept),
    .data_i     (s_axis.s_axis_tdata),
    .seg_last_o (seg_last),
    .row_o      (row)
  );

  always_comb begin
    state_d  = state_q;
    parity_d = parity_q;
    index_d  = index_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (i_start) begin
          state_d  = StLoad;
          parity_d = 1'b0;
          index_d  = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          if (seg_last) begin
            parity_d = ~parity_q;
            if (parity_q) index_d = index_q + AW'(1);
          end
          if (s_axis.s_axis_tlast) state_d = final_beat ? StDone : StErr;
          else if (final_beat)     state_d = StErr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= StIdle;
      parity_q  <= 1'b0;
      index_q   <= '0;
      o_wr_en   <= 1'b0;
      o_wr_sel  <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      index_q  <= index_d;
      o_wr_en  <= row_write;
      if (row_write) begin
        o_wr_sel  <= parity_q;
        o_wr_addr <= index_q;
        o_wr_data <= row;
      end
    end
  end

  assign o_done = (state_q == StDone);
  assign o_err  = (state_q == StErr);

endmodule

// File: tb/tb_code_word_loader.sv
// Directed bench for code_word_loader: clean, throttled, framing-error, reset and restart loads.
module tb_code_word_loader;
  import cw_pkg::*;

  localparam int unsigned BW    = 256;
  localparam int unsigned RowW  = 1024;
  localparam int unsigned AW    = 6;
  localparam int          Beats = 512;
  localparam int          Rows  = 128;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            wr_en, wr_sel, done, err;
  logic [AW-1:0]   wr_addr;
  logic [RowW-1:0] wr_data;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] salt = 32'h0;

  typedef struct {
    logic            sel;
    logic [AW-1:0]   addr;
    logic [RowW-1:0] data;
    logic            done;
  } wr_t;
  wr_t log_q[$];

  code_word_loader_if #(.BW(BW)) axis ();

  code_word_loader dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_start   (start),
    .s_axis    (axis),
    .o_wr_en   (wr_en),
    .o_wr_sel  (wr_sel),
    .o_wr_addr (wr_addr),
    .o_wr_data (wr_data),
    .o_done    (done),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) log_q.push_back('{wr_sel, wr_addr, wr_data, done});
  end

  function automatic logic [BW-1:0] beat_data(input int b);
    logic [BW-1:0] d;
    for (int w = 0; w < 8; w++) d[w*32 +: 32] = ((32'(b) << 8) | 32'(w)) ^ salt;
    return d;
  endfunction

  function automatic logic [RowW-1:0] exp_row(input int r);
    return {beat_data(4*r+3), beat_data(4*r+2), beat_data(4*r+1), beat_data(4*r)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends beats 0..n-1; tlast on beat last_at (-1 = never).
  task automatic drive_beats(input int n, input int last_at, input bit throttle);
    int b = 0;
    int guard = 0;
    bit ok;
    while (b < n && guard < 4*n + 100) begin
      axis.s_axis_tvalid = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
      axis.s_axis_tdata  = beat_data(b);
      axis.s_axis_tlast  = (b == last_at);
      ok = axis.s_axis_tvalid && axis.s_axis_tready;
      tick();
      if (ok) b++;
      guard++;
    end
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tlast  = 1'b0;
    n_cmp++;
    if (b != n) begin
      n_fail++;
      $display("FAIL drive_timeout: accepted %0d beats, required %0d", b, n);
    end
  endtask

  task automatic test_reset();
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tlast  = 1'b0;
    axis.s_axis_tdata  = '0;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({axis.s_axis_tready, wr_en, wr_sel, done, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 00000",
               {axis.s_axis_tready, wr_en, wr_sel, done, err});
    end
    n_cmp++;
    if (wr_addr !== '0 || wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset_wr_bus: addr %0d data %h, required 0", wr_addr, wr_data[63:0]);
    end
    rst_n = 1'b1;
    axis.s_axis_tvalid = 1'b1;
    repeat (6) tick();
    axis.s_axis_tvalid = 1'b0;
    n_cmp++;
    if (axis.s_axis_tready !== 1'b0 || log_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_no_accept: tready %b writes %0d, required 0 0",
               axis.s_axis_tready, log_q.size());
    end
  endtask

  task automatic test_clean_load();
    salt = 32'h1234_0000;
    log_q.delete();
    pulse_start();
    drive_beats(Beats, Beats - 1, 1'b0);
    tick();
    n_cmp++;
    if (log_q.size() != Rows) begin
      n_fail++;
      $display("FAIL clean_count: got %0d writes, required %0d", log_q.size(), Rows);
    end
    for (int i = 0; i < log_q.size() && i < Rows; i++) begin
      n_cmp++;
      if (log_q[i].sel !== 1'(i % 2) || log_q[i].addr !== AW'(i / 2) ||
          log_q[i].data !== exp_row(i)) begin
        n_fail++;
        $display("FAIL clean_row%0d: sel %b addr %0d data %h, required sel %0d addr %0d data %h",
                 i, log_q[i].sel, log_q[i].addr, log_q[i].data[63:0], i % 2, i / 2,
                 exp_row(i)[63:0]);
      end
    end
    if (log_q.size() == Rows) begin
      n_cmp++;
      if (log_q[11].sel !== 1'b1 || log_q[11].addr !== 6'd5) begin
        n_fail++;
        $display("FAIL clean_idx5_odd: sel %b addr %0d, required sel 1 addr 5",
                 log_q[11].sel, log_q[11].addr);
      end
      n_cmp++;
      if (log_q[Rows-1].done !== 1'b1 || log_q[Rows-2].done !== 1'b0) begin
        n_fail++;
        $display("FAIL clean_done_timing: last %b prev %b, required 1 0",
                 log_q[Rows-1].done, log_q[Rows-2].done);
      end
    end
    n_cmp++;
    if ({done, err, axis.s_axis_tready} !== 3'b100) begin
      n_fail++;
      $display("FAIL clean_status: done/err/tready %b, required 100",
               {done, err, axis.s_axis_tready});
    end
  endtask

  task automatic test_restart();
    salt = 32'h00AB_CD00;
    log_q.delete();
    pulse_start();
    n_cmp++;
    if ({done, err, axis.s_axis_tready} !== 3'b001) begin
      n_fail++;
      $display("FAIL restart_clear: done/err/tready %b, required 001",
               {done, err, axis.s_axis_tready});
    end
    drive_beats(Beats, Beats - 1, 1'b0);
    tick();
    n_cmp++;
    if (log_q.size() != Rows) begin
      n_fail++;
      $display("FAIL restart_count: got %0d writes, required %0d", log_q.size(), Rows);
    end
    if (log_q.size() > 0) begin
      n_cmp++;
      if (log_q[0].sel !== 1'b0 || log_q[0].addr !== '0 || log_q[0].data !== exp_row(0)) begin
        n_fail++;
        $display("FAIL restart_first: sel %b addr %0d data %h, required 0 0 %h",
                 log_q[0].sel, log_q[0].addr, log_q[0].data[63:0], exp_row(0)[63:0]);
      end
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_done: got %b, required 1", done);
    end
  endtask

  task automatic test_throttle();
    salt = 32'h5A5A_0F0F;
    log_q.delete();
    pulse_start();
    drive_beats(Beats, Beats - 1, 1'b1);
    tick();
    n_cmp++;
    if (log_q.size() != Rows) begin
      n_fail++;
      $display("FAIL throttle_count: got %0d writes, required %0d", log_q.size(), Rows);
    end
    for (int i = 0; i < log_q.size() && i < Rows; i++) begin
      n_cmp++;
      if (log_q[i].sel !== 1'(i % 2) || log_q[i].addr !== AW'(i / 2) ||
          log_q[i].data !== exp_row(i)) begin
        n_fail++;
        $display("FAIL throttle_row%0d: sel %b addr %0d data %h, required %0d %0d %h",
                 i, log_q[i].sel, log_q[i].addr, log_q[i].data[63:0], i % 2, i / 2,
                 exp_row(i)[63:0]);
      end
    end
    n_cmp++;
    if ({done, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL throttle_status: done/err %b, required 10", {done, err});
    end
  endtask

  task automatic test_early_tlast();
    salt = 32'hC0DE_0000;
    log_q.delete();
    pulse_start();
    drive_beats(10, 9, 1'b0);
    tick();
    tick();
    n_cmp++;
    if (log_q.size() != 2) begin
      n_fail++;
      $display("FAIL early_count: got %0d writes, required 2", log_q.size());
    end
    for (int i = 0; i < log_q.size() && i < 2; i++) begin
      n_cmp++;
      if (log_q[i].sel !== 1'(i) || log_q[i].addr !== '0 || log_q[i].data !== exp_row(i)) begin
        n_fail++;
        $display("FAIL early_row%0d: sel %b addr %0d data %h, required %0d 0 %h",
                 i, log_q[i].sel, log_q[i].addr, log_q[i].data[63:0], i, exp_row(i)[63:0]);
      end
    end
    n_cmp++;
    if ({done, err, axis.s_axis_tready} !== 3'b010) begin
      n_fail++;
      $display("FAIL early_status: done/err/tready %b, required 010",
               {done, err, axis.s_axis_tready});
    end
  endtask

  task automatic test_missing_tlast();
    salt = 32'h0F0F_1111;
    log_q.delete();
    pulse_start();
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL missing_err_clear: got %b, required 0", err);
    end
    drive_beats(Beats, -1, 1'b0);
    tick();
    n_cmp++;
    if (log_q.size() != Rows) begin
      n_fail++;
      $display("FAIL missing_count: got %0d writes, required %0d", log_q.size(), Rows);
    end
    if (log_q.size() == Rows) begin
      n_cmp++;
      if (log_q[Rows-1].sel !== 1'b1 || log_q[Rows-1].addr !== 6'd63 ||
          log_q[Rows-1].data !== exp_row(Rows - 1)) begin
        n_fail++;
        $display("FAIL missing_last_row: sel %b addr %0d data %h, required 1 63 %h",
                 log_q[Rows-1].sel, log_q[Rows-1].addr, log_q[Rows-1].data[63:0],
                 exp_row(Rows - 1)[63:0]);
      end
    end
    n_cmp++;
    if ({done, err} !== 2'b01) begin
      n_fail++;
      $display("FAIL missing_status: done/err %b, required 01", {done, err});
    end
  endtask

  task automatic test_reset_mid_load();
    salt = 32'h7777_0000;
    log_q.delete();
    pulse_start();
    drive_beats(101, -1, 1'b0);
    rst_n = 1'b0;
    axis.s_axis_tvalid = 1'b1;
    tick();
    n_cmp++;
    if ({axis.s_axis_tready, wr_en, wr_sel, done, err} !== 5'b0 ||
        wr_addr !== '0 || wr_data !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: flags %b addr %0d data %h, required all 0",
               {axis.s_axis_tready, wr_en, wr_sel, done, err}, wr_addr, wr_data[63:0]);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    axis.s_axis_tvalid = 1'b0;
    n_cmp++;
    if (log_q.size() != 25 || axis.s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_writes: writes %0d tready %b, required 25 0",
               log_q.size(), axis.s_axis_tready);
    end
    salt = 32'h8888_0000;
    log_q.delete();
    pulse_start();
    drive_beats(Beats, Beats - 1, 1'b0);
    tick();
    n_cmp++;
    if (log_q.size() != Rows || done !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_reload: writes %0d done %b err %b, required %0d 1 0",
               log_q.size(), done, err, Rows);
    end
    if (log_q.size() == Rows) begin
      n_cmp++;
      if (log_q[50].sel !== 1'b0 || log_q[50].addr !== 6'd25 ||
          log_q[50].data !== exp_row(50)) begin
        n_fail++;
        $display("FAIL midreset_row50: sel %b addr %0d data %h, required 0 25 %h",
                 log_q[50].sel, log_q[50].addr, log_q[50].data[63:0], exp_row(50)[63:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_load();
    test_restart();
    test_throttle();
    test_early_tlast();
    test_missing_tlast();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
